// File: rtl/demux_4_if.sv
// Data, select and routed output lanes of the registered 1-to-4 demultiplexer.
// Lane k of y occupies bits [k*W +: W].
interface demux_4_if #(
    parameter int W = 1
);
    logic [W-1:0]   i;
    logic [1:0]     s;
    logic [4*W-1:0] y;

    modport master (output i, output s, input y);
    modport slave  (input i, input s, output y);
endinterface

// File: rtl/demux_4.sv
// Purpose: route i onto lane s of y, all other lanes zero.
// Latency: 1 cycle, y registered and loaded on every non-reset edge.
// Backpressure: none, no handshake; the output is overwritten every cycle.
module demux_4 #(
    parameter int W = 1
) (
    input  logic     clk,
    input  logic     rst,
    demux_4_if.slave bus
);

    logic [4*W-1:0] y_nxt;
    logic [4*W-1:0] y_q;

    always_comb begin
        y_nxt = '0;
        case (bus.s)
            2'd0: y_nxt[0*W +: W] = bus.i;
            2'd1: y_nxt[1*W +: W] = bus.i;
            2'd2: y_nxt[2*W +: W] = bus.i;
            2'd3: y_nxt[3*W +: W] = bus.i;
        endcase
    end

    // Reset wins over the data load.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_nxt;
        end
    end

    assign bus.y = y_q;

endmodule

// File: tb/tb_demux_4.sv
// Scoreboarded bench for demux_4 at W=1 and W=8 driven in lockstep.
module tb_demux_4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    demux_4_if #(.W(1)) b1 ();
    demux_4_if #(.W(8)) b8 ();

    demux_4 #(.W(1)) u_w1 (.clk(clk), .rst(rst), .bus(b1.slave));
    demux_4 #(.W(8)) u_w8 (.clk(clk), .rst(rst), .bus(b8.slave));

    logic [31:0] q1 [$];
    logic [31:0] q8 [$];
    int          qs [$];

    // Reference: data shifted into lane s of a zero word, or zero under reset.
    function automatic logic [31:0] ref_map(input int w, input logic [7:0] d,
                                            input logic [1:0] sel, input logic r);
        logic [31:0] v;
        if (r) return 32'd0;
        v = 32'(d) & ((32'd1 << w) - 32'd1);
        return v << (w * int'(sel));
    endfunction

    always @(posedge clk) begin
        q1.push_back(ref_map(1, {7'd0, b1.i}, b1.s, rst));
        q8.push_back(ref_map(8, b8.i, b8.s, rst));
        qs.push_back(rst ? -1 : int'(b8.s));
    end

    always @(negedge clk) begin
        logic [31:0] e1, e8, a1;
        int          es;
        if (q8.size() > 0) begin
            e1 = q1.pop_front();
            e8 = q8.pop_front();
            es = qs.pop_front();
            a1 = 32'(b1.y);
            total++;
            if (a1 !== e1) begin
                bad++;
                $display("FAIL y_w1 t=%0t got=%h want=%h", $time, a1, e1);
            end
            total++;
            if (b8.y !== e8) begin
                bad++;
                $display("FAIL y_w8 t=%0t got=%h want=%h", $time, b8.y, e8);
            end
            for (int k = 0; k < 4; k++) begin
                if (k != es) begin
                    total++;
                    if (b8.y[k*8 +: 8] !== 8'h00) begin
                        bad++;
                        $display("FAIL idle_lane%0d t=%0t got=%h want=00", k, $time, b8.y[k*8 +: 8]);
                    end
                end
            end
        end
    end

    task automatic drive(input logic r, input logic d1, input logic [7:0] d8, input logic [1:0] sel);
        @(negedge clk);
        rst  = r;
        b1.i = d1;
        b8.i = d8;
        b1.s = sel;
        b8.s = sel;
    endtask

    initial begin
        rst  = 1'b1;
        b1.i = 1'b1;
        b8.i = 8'h5A;
        b1.s = 2'd2;
        b8.s = 2'd2;

        drive(1'b1, 1'b1, 8'h5A, 2'd2);
        drive(1'b1, 1'b1, 8'h5A, 2'd2);
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 8'h00, 2'(k));
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 8'hA5, 2'(k));
        drive(1'b0, 1'b1, 8'hA5, 2'd2);
        drive(1'b0, 1'b1, 8'hA5, 2'd0);
        drive(1'b0, 1'b1, 8'h3C, 2'd3);
        drive(1'b1, 1'b1, 8'h3C, 2'd3);
        drive(1'b0, 1'b1, 8'h3C, 2'd1);

        for (int n = 0; n < 1000; n++) begin
            drive(($urandom_range(0, 19) == 0), 1'($urandom), 8'($urandom), 2'($urandom));
        end

        drive(1'b0, 1'b0, 8'h00, 2'd0);
        repeat (3) @(negedge clk);

        // The monitor must have consumed every cycle's expectation.
        total++;
        if (total < 4000 || q8.size() > 1) begin
            bad++;
            $display("FAIL monitor_coverage got=%0d checks, %0d pending want>=4000, <=1", total, q8.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
